// File: rtl/matrix_stream_loader_if.sv
// Stream and multiplier bundle for matrix_stream_loader.
// master = the loader; slave = the byte source, multiplier and result sink.
interface matrix_stream_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] A;
  logic [71:0] B;
  logic        Enable;
  logic        done;
  logic [71:0] C;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    input  in_data, in_valid, done, C, out_ready,
    output in_ready, A, B, Enable, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, done, C, out_ready,
    input  in_ready, A, B, Enable, out_data, out_valid
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// Loads two 3x3 byte matrices from a stream, runs an external multiplier
// under a watchdog, then streams the 9 result bytes back out.
module matrix_stream_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  matrix_stream_loader_if.master bus,
  output logic                  error
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [71:0]     a_q, a_d;
  logic [71:0]     b_q, b_d;
  logic [71:0]     res_q, res_d;
  logic            en_q, en_d;
  logic            ov_q, ov_d;
  logic [7:0]      od_q, od_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wd_d    = wd_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    en_d    = en_q;
    ov_d    = ov_q;
    od_d    = od_q;
    err_d   = err_q;

    if (clear) begin
      state_d = LOAD_A;
      k_d     = '0;
      wd_d    = '0;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      en_d    = 1'b0;
      ov_d    = 1'b0;
      od_d    = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (bus.in_valid) begin
            for (int unsigned i = 0; i < 9; i++)
              if (k_q == 4'(i)) a_d[i*8 +: 8] = bus.in_data;
            if (k_q == 4'd8) begin
              state_d = LOAD_B;
              k_d     = '0;
            end else begin
              k_d = k_q + 4'd1;
            end
          end
        end
        LOAD_B: begin
          if (bus.in_valid) begin
            for (int unsigned i = 0; i < 9; i++)
              if (k_q == 4'(i)) b_d[i*8 +: 8] = bus.in_data;
            if (k_q == 4'd8) begin
              state_d = RUN;
              k_d     = '0;
              wd_d    = '0;
              en_d    = 1'b1;
            end else begin
              k_d = k_q + 4'd1;
            end
          end
        end
        RUN: begin
          // done is checked first so it wins over a same-cycle timeout
          if (bus.done) begin
            state_d = DRAIN;
            k_d     = '0;
            res_d   = bus.C;
            en_d    = 1'b0;
            ov_d    = 1'b1;
            od_d    = bus.C[7:0];
          end else if (wd_q == WD_LAST) begin
            state_d = LOAD_A;
            wd_d    = '0;
            en_d    = 1'b0;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (k_q == 4'd8) begin
              state_d = LOAD_A;
              k_d     = '0;
              ov_d    = 1'b0;
            end else begin
              k_d = k_q + 4'd1;
              // preload the next byte so out_data stays a plain register
              for (int unsigned i = 1; i < 9; i++)
                if (k_q == 4'(i - 1)) od_d = res_q[i*8 +: 8];
            end
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD_A;
      k_q     <= '0;
      wd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      en_q    <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wd_q    <= wd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      en_q    <= en_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = reset && ((state_q == LOAD_A) || (state_q == LOAD_B));
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.Enable    = en_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign error         = err_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Randomised scoreboard bench for matrix_stream_loader with a behavioural
// 3x3 multiplier on the bus.
module tb_matrix_stream_loader;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic error;

  matrix_stream_loader_if bus();

  matrix_stream_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus),
    .error (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic        mult_done = 1'b0;
  logic        stray_done = 1'b0;
  logic        mult_stub = 1'b0;
  logic [71:0] mult_c = '0;
  logic [71:0] stray_c = '0;
  int          rdy_mode = 0;
  int          xfer_cnt = 0;
  logic [7:0]  ma[9], mb[9];
  logic [7:0]  mam[9], mbm[9];
  logic [7:0]  mon_e;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  assign bus.done = mult_done | stray_done;
  assign bus.C    = stray_done ? stray_c : mult_c;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [71:0] pack(input logic [7:0] m[9]);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = m[i];
    return r;
  endfunction

  function automatic logic [71:0] matmul(input logic [7:0] a[9], input logic [7:0] b[9]);
    logic [71:0] r;
    int unsigned s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int t = 0; t < 3; t++) s += a[i*3+t] * b[t*3+j];
        r[(i*3+j)*8 +: 8] = 8'(s);
      end
    return r;
  endfunction

  // behavioural multiplier: reads A/B when Enable rises, answers after 1..5 cycles
  initial forever begin
    @(negedge clk);
    if (bus.Enable && !mult_stub) begin
      for (int i = 0; i < 9; i++) begin
        mam[i] = bus.A[i*8 +: 8];
        mbm[i] = bus.B[i*8 +: 8];
      end
      mult_c = matmul(mam, mbm);
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1 mult_done = 1'b1;
      @(posedge clk);
      #1 mult_done = 1'b0;
      for (int w = 0; w < 20 && bus.Enable; w++) @(negedge clk);
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // monitor: a transfer seen at the negedge completes at the following posedge
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      prev_stall = 1'b0;
      continue;
    end
    if (prev_stall) begin
      check("stall_valid", 72'(bus.out_valid), 72'(1));
      check("stall_data", 72'(bus.out_data), 72'(prev_data));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d expected no output", bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", 72'(bus.out_data), 72'(mon_e));
        xfer_cnt++;
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
  end

  task automatic send(input logic [7:0] d, input int gap);
    int w;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic pulse_stray();
    stray_c    = {$urandom, $urandom, 8'($urandom)};
    stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
  endtask

  task automatic loaded(input bit push);
    logic [71:0] r;
    @(negedge clk);
    check("enable_after_load", 72'(bus.Enable), 72'(1));
    check("in_ready_run", 72'(bus.in_ready), 72'(0));
    check("A_loaded", bus.A, pack(ma));
    check("B_loaded", bus.B, pack(mb));
    if (push) begin
      r = matmul(ma, mb);
      for (int i = 0; i < 9; i++) exp_q.push_back(r[i*8 +: 8]);
    end
  endtask

  task automatic load(input int maxgap, input bit push);
    for (int i = 0; i < 9; i++) send(ma[i], $urandom_range(0, maxgap));
    for (int i = 0; i < 9; i++) send(mb[i], $urandom_range(0, maxgap));
    loaded(push);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drain_complete", 72'(exp_q.size()), 72'(0));
    @(posedge clk);
    #1;
    check("in_ready_after_drain", 72'(bus.in_ready), 72'(1));
    check("out_valid_after_drain", 72'(bus.out_valid), 72'(0));
  endtask

  task automatic set_ref();
    for (int i = 0; i < 9; i++) begin
      ma[i] = 8'(i + 1);
      mb[i] = 8'(9 - i);
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < 9; i++) begin
      ma[i] = 8'($urandom);
      mb[i] = 8'($urandom);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int en_cnt, ov_cnt, base, w;
    logic [7:0] held;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_in_ready", 72'(bus.in_ready), 72'(0));
    check("rst_enable", 72'(bus.Enable), 72'(0));
    check("rst_out_valid", 72'(bus.out_valid), 72'(0));
    check("rst_error", 72'(error), 72'(0));
    check("rst_out_data", 72'(bus.out_data), 72'(0));
    check("rst_A", bus.A, 72'(0));
    check("rst_B", bus.B, 72'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("in_ready_release", 72'(bus.in_ready), 72'(1));
    @(posedge clk);
    #1;

    // streaming and multiply
    set_ref();
    rdy_mode = 0;
    load(0, 1'b1);
    wait_drain();

    // output backpressure
    rdy_mode = 1;
    load(0, 1'b1);
    wait_drain();
    rdy_mode = 0;

    // input gaps
    load(3, 1'b1);
    wait_drain();

    // watchdog timeout
    mult_stub = 1'b1;
    load(0, 1'b0);
    en_cnt = 0;
    ov_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.Enable) en_cnt++;
      if (bus.out_valid) ov_cnt++;
      @(negedge clk);
    end
    check("timeout_enable_cycles", 72'(en_cnt), 72'(16));
    check("timeout_no_output", 72'(ov_cnt), 72'(0));
    check("timeout_error", 72'(error), 72'(1));
    check("timeout_load_a", 72'(bus.in_ready), 72'(1));
    mult_stub = 1'b0;
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clear_error", 72'(error), 72'(0));

    // clear mid-load, then reset mid-drain
    for (int i = 0; i < 5; i++) send(8'($urandom), 0);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clear_A", bus.A, 72'(0));
    check("clear_in_ready", 72'(bus.in_ready), 72'(1));
    set_ref();
    load(0, 1'b1);
    base = xfer_cnt;
    w = 0;
    while (xfer_cnt < base + 3 && w < 400) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("three_outputs", 72'(xfer_cnt - base), 72'(3));
    #1 reset = 1'b0;
    #1;
    check("rst_drain_out_valid", 72'(bus.out_valid), 72'(0));
    check("rst_drain_out_data", 72'(bus.out_data), 72'(0));
    check("rst_drain_in_ready", 72'(bus.in_ready), 72'(0));
    check("rst_drain_A", bus.A, 72'(0));
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("in_ready_release2", 72'(bus.in_ready), 72'(1));
    @(posedge clk);
    #1;

    // stray done in LOAD_A and in DRAIN
    set_rand();
    rdy_mode = 2;
    for (int i = 0; i < 9; i++) begin
      send(ma[i], 0);
      if (i == 3) begin
        pulse_stray();
        check("stray_load_in_ready", 72'(bus.in_ready), 72'(1));
        check("stray_load_enable", 72'(bus.Enable), 72'(0));
        check("stray_load_out_valid", 72'(bus.out_valid), 72'(0));
      end
    end
    for (int i = 0; i < 9; i++) send(mb[i], 0);
    loaded(1'b1);
    w = 0;
    while (!bus.out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_reached", 72'(bus.out_valid), 72'(1));
    held = bus.out_data;
    @(posedge clk);
    #1;
    pulse_stray();
    @(negedge clk);
    check("stray_drain_data", 72'(bus.out_data), 72'(held));
    check("stray_drain_valid", 72'(bus.out_valid), 72'(1));
    rdy_mode = 0;
    wait_drain();

    // random rounds
    for (int r = 0; r < 4; r++) begin
      set_rand();
      rdy_mode = int'($urandom_range(0, 1));
      load(2, 1'b1);
      wait_drain();
    end
    rdy_mode = 0;
    check("final_error", 72'(error), 72'(0));

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_stream_loader.md
MATRIX_STREAM_LOADER -- requirements
Module: matrix_stream_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, meaning max cycles in RUN waiting for done before abort; SHALL be ≥2.
REQ-002 Clock  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; reset==0 SHALL immediately force reset state.
REQ-004 clear  in  1  synchronous abort, active-high.
REQ-005 in_data  in  8  operand byte stream; in_valid  in  1; in_ready  out  1.
REQ-006 A  out  72  and B  out  72: operand matrices to the multiplier; element (i,j) at bits [(i*3+j)*8 +: 8].
REQ-007 Enable  out  1  start and hold request to the multiplier.
REQ-008 done  in  1  and C  in  72: multiplier completion flag and result, same element packing as A.
REQ-009 out_data  out  8; out_valid  out  1; out_ready  in  1: result byte stream.
REQ-010 error  out  1  sticky timeout flag.

Function
REQ-011 The block SHALL use states LOAD_A, LOAD_B, RUN and DRAIN, with a 4-bit element index k = 0..8.
REQ-012 In LOAD_A/LOAD_B, in_ready SHALL be 1, and a byte SHALL be accepted on a rising edge with in_valid&in_ready; the accepted byte SHALL be written to A (or B) bits [k*8 +: 8], and k SHALL then increment.
REQ-013 Acceptance of k=8: LOAD_A→LOAD_B with k=0; LOAD_B→RUN with k=0; Enable SHALL be 1 in the cycle after the 18th accepted byte.
REQ-014 In RUN and DRAIN, in_ready SHALL be 0, and A and B SHALL hold stable.
REQ-015 In RUN, Enable SHALL be held at 1, and a watchdog SHALL count RUN cycles from 0.
REQ-016 done sampled 1 in RUN SHALL capture C into an internal result register, set Enable=0 on the next cycle, and transition to DRAIN with k=0.
REQ-017 done outside RUN SHALL be ignored.
REQ-018 If the watchdog reaches TIMEOUT_CYCLES-1 without done, the block SHALL set error=1, set Enable=0, and go to LOAD_A; the result SHALL not be captured, and DRAIN SHALL be skipped.
REQ-019 If done and the timeout occur in the same cycle, done SHALL win.
REQ-020 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal result[k*8 +: 8]; k SHALL advance on out_valid&out_ready.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-022 After the 9th output transfer, the block SHALL go to LOAD_A with out_valid=0 on the next cycle; a new load SHALL then proceed without reset.
REQ-023 Registered outputs (Enable, out_valid, out_data, error) SHALL have no combinational path from in_valid/out_ready; in_ready and out_valid MAY be decoded directly from state.
REQ-024 clear=1 on an edge SHALL, in any state, go to LOAD_A, zero k, the watchdog, A, B and the result, and deassert Enable and out_valid.
REQ-025 clear SHALL also reset error to 0, and SHALL take priority over all other events in that cycle.
REQ-026 error SHALL remain 1 until clear or reset.

Reset
REQ-027 While reset=0, the block SHALL hold state LOAD_A, k=0 and watchdog=0.
REQ-028 While reset=0, A, B, C-capture and out_data SHALL be 0.
REQ-029 While reset=0, Enable, out_valid and error SHALL be 0, and in_ready SHALL be 0.
REQ-030 On release of reset, in_ready SHALL become 1 in LOAD_A.
REQ-031 reset asserted mid-RUN or mid-DRAIN SHALL drop Enable and out_valid asynchronously, and any partial transfer SHALL be discarded.

Verification
REQ-032 Scenario 1, streaming and multiply: stream bytes 1..9 then 9..1 back-to-back with out_ready=1 and the real multiplier connected.
- Required: A[7:0]=1, A[71:64]=9, B[7:0]=9, and Enable=1 one cycle after the 18th accept.
- Required: out_data sequence 30,24,18,84,69,54,138,114,90, then in_ready=1.
REQ-033 Scenario 2, output backpressure: same stimulus as Scenario 1, with out_ready toggling 1/0 per cycle.
- Required: same 9 bytes in order, no duplicates or drops, and out_data stable whenever stalled.
REQ-034 Scenario 3, input gaps: random idle in_valid cycles inserted.
- Required: A and B identical to Scenario 1; in_data is not sampled when in_valid=0.
REQ-035 Scenario 4, timeout: TIMEOUT_CYCLES=16 with a stub that never asserts done.
- Required: Enable=1 for exactly 16 cycles, then Enable=0 and error=1, state LOAD_A, out_valid never 1.
- Then clear: error=0.
REQ-036 Scenario 5, clear and reset mid-operation: clear after 5 A bytes, then 18 fresh bytes 1..9/9..1.
- Required: loaded A/B equal Scenario 1.
- Then reset=0 during DRAIN after 3 outputs: out_valid=0 immediately, and out_data=0.
REQ-037 Scenario 6, stray done: a done pulse in LOAD_A and in DRAIN.
- Required: no state change, no C recapture, and output bytes unchanged.
